mips_dmem_bridge: RTL and testbench

- Sits directly downstream of the CPU's memory-stage port: takes its single-cycle data-memory requests (address, byte-lane write enables, read enable, write data) and converts them into a multi-cycle request/grant/response bus transaction.
- Stalls the whole pipeline through the CPU's en input while a transaction is outstanding.
- Returns read data with the one-cycle-after-access timing the CPU's M stage expects.
- Contains a timeout watchdog so a hung bus cannot wedge the core.

---
 rtl/mips_mem_pkg.sv | 14 +
 rtl/mips_dmem_timeout.sv | 31 +++
 rtl/mips_dmem_bridge.sv | 122 ++++++++++++
 tb/tb_mips_dmem_bridge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-side bus bridges.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      DONE   = 2'd3
   } mem_state_t;

   localparam int          BYTE_LANES       = 4;
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/mips_dmem_timeout.sv
// Clearable saturating cycle counter; expire pulses on the tick that reaches LIMIT.
module mips_dmem_timeout #(
   parameter int LIMIT = 255,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic tick,
   output logic expire
);

   localparam logic [W-1:0] LAST = W'(LIMIT - 1);
   localparam logic [W-1:0] MAX  = W'(LIMIT);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (tick && (count != MAX)) begin
         count <= count + 1'b1;
      end
   end

   // Flag the tick that would bring the count to LIMIT, so the owner aborts after exactly LIMIT cycles.
   assign expire = tick && !clr && (count >= LAST);

endmodule

// File: rtl/mips_dmem_bridge.sv
// Converts single-cycle CPU data-memory accesses into a req/gnt/rvalid bus transaction,
// stalling the pipeline through cpu_en while the transaction is outstanding.
module mips_dmem_bridge
   import mips_mem_pkg::*;
#(
   parameter int                ADDR_W         = 32,
   parameter int                DATA_W         = 32,
   parameter int                TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [BYTE_LANES-1:0] cpu_mem_write_en,
   input  logic                  cpu_mem_read_en,
   input  logic [ADDR_W-1:0]     cpu_mem_addr,
   input  logic [DATA_W-1:0]     cpu_mem_write_data,
   output logic [DATA_W-1:0]     cpu_mem_read_data,
   output logic                  cpu_en,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [BYTE_LANES-1:0] bus_be,
   output logic [ADDR_W-1:0]     bus_addr,
   output logic [DATA_W-1:0]     bus_wdata,
   input  logic                  bus_gnt,
   input  logic                  bus_rvalid,
   input  logic [DATA_W-1:0]     bus_rdata,
   output logic                  bus_error
);

   // state  | meaning
   // IDLE   | no transaction; a new CPU access is launched here only
   // REQ    | bus_req held, waiting for bus_gnt
   // WAIT_R | read granted, waiting for bus_rvalid
   // DONE   | access retires this cycle; inputs still show it, so never relaunch

   mem_state_t        state;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              is_wr;
   logic              access;
   logic              to_clr;
   logic              to_tick;
   logic              to_expire;

   assign is_wr  = |cpu_mem_write_en;
   assign access = is_wr | cpu_mem_read_en;

   // Bus fields follow the CPU inputs directly; the CPU holds them stable while stalled.
   assign bus_we    = is_wr;
   assign bus_be    = is_wr ? cpu_mem_write_en : {BYTE_LANES{1'b1}};
   assign bus_addr  = {cpu_mem_addr[ADDR_W-1:2], 2'b00};
   assign bus_wdata = cpu_mem_write_data;

   assign cpu_mem_read_data = rdata_q;
   assign bus_error         = err_q;

   // Request is not offered from IDLE while stalled so a grant can never be lost there.
   assign bus_req = ((state == IDLE) && en && access) || (state == REQ);

   always_comb begin
      cpu_en = 1'b0;
      case (state)
         IDLE:    cpu_en = en & ~access;
         DONE:    cpu_en = en;
         default: cpu_en = 1'b0;
      endcase
   end

   assign to_tick = en && ((state == REQ) || (state == WAIT_R));
   assign to_clr  = en && (((state == IDLE) && access) ||
                           ((state == REQ) && bus_gnt && !is_wr));

   mips_dmem_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (to_clr),
      .tick   (to_tick),
      .expire (to_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (en) begin
         case (state)
            IDLE: begin
               if (access) begin
                  if (bus_gnt) state <= is_wr ? DONE : WAIT_R;
                  else         state <= REQ;
               end
            end
            REQ: begin
               if (bus_gnt) begin
                  state <= is_wr ? DONE : WAIT_R;
               end else if (to_expire) begin
                  state <= DONE;
                  err_q <= 1'b1;
                  if (!is_wr) rdata_q <= ERR_DATA;
               end
            end
            WAIT_R: begin
               if (bus_rvalid) begin
                  rdata_q <= bus_rdata;
                  state   <= DONE;
               end else if (to_expire) begin
                  rdata_q <= ERR_DATA;
                  err_q   <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Directed bench for mips_dmem_bridge: IDLE decode vector table plus multi-cycle sequences.
module tb_mips_dmem_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  cpu_mem_write_en;
   logic        cpu_mem_read_en;
   logic [31:0] cpu_mem_addr;
   logic [31:0] cpu_mem_write_data;
   logic [31:0] cpu_mem_read_data;
   logic        cpu_en;
   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic        bus_error;

   int passed = 0;
   int total  = 0;
   int hs     = 0;

   always #5 clk = ~clk;

   mips_dmem_bridge #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .en                 (en),
      .cpu_mem_write_en   (cpu_mem_write_en),
      .cpu_mem_read_en    (cpu_mem_read_en),
      .cpu_mem_addr       (cpu_mem_addr),
      .cpu_mem_write_data (cpu_mem_write_data),
      .cpu_mem_read_data  (cpu_mem_read_data),
      .cpu_en             (cpu_en),
      .bus_req            (bus_req),
      .bus_we             (bus_we),
      .bus_be             (bus_be),
      .bus_addr           (bus_addr),
      .bus_wdata          (bus_wdata),
      .bus_gnt            (bus_gnt),
      .bus_rvalid         (bus_rvalid),
      .bus_rdata          (bus_rdata),
      .bus_error          (bus_error)
   );

   // Handshake counter: a bus transaction starts on each accepted req/gnt.
   always @(posedge clk) begin
      if (!rst && en && bus_req && bus_gnt) hs <= hs + 1;
   end

   typedef struct {
      logic [3:0]  we;
      logic        re;
      logic        en;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        x_req;
      logic        x_we;
      logic [3:0]  x_be;
      logic [31:0] x_addr;
      logic        x_cpu_en;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
      else passed++;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_mem_write_en   = 4'h0;
      cpu_mem_read_en    = 1'b0;
      cpu_mem_addr       = 32'h0;
      cpu_mem_write_data = 32'h0;
      bus_gnt            = 1'b0;
      bus_rvalid         = 1'b0;
      bus_rdata          = 32'h0;
   endtask

   initial begin
      int req_cycles;
      int stall;

      vecs[0] = '{4'h0, 1'b1, 1'b1, 32'h0000_0100, 32'h0,          1'b1, 1'b0, 4'hF, 32'h0000_0100, 1'b0};
      vecs[1] = '{4'h2, 1'b0, 1'b1, 32'h0000_0203, 32'h0000_AB00,  1'b1, 1'b1, 4'h2, 32'h0000_0200, 1'b0};
      vecs[2] = '{4'h0, 1'b0, 1'b1, 32'h0000_0007, 32'h1111_1111,  1'b0, 1'b0, 4'hF, 32'h0000_0004, 1'b1};
      vecs[3] = '{4'h8, 1'b1, 1'b1, 32'h0000_1001, 32'h7700_0000,  1'b1, 1'b1, 4'h8, 32'h0000_1000, 1'b0};
      vecs[4] = '{4'hF, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0123_4567,  1'b1, 1'b1, 4'hF, 32'hFFFF_FFFC, 1'b0};
      vecs[5] = '{4'h0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,          1'b0, 1'b0, 4'hF, 32'h0000_0010, 1'b0};

      rst = 1'b1;
      en  = 1'b1;
      idle_inputs();
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      chk("reset_bus_req",   {31'd0, bus_req},   32'd0);
      chk("reset_bus_error", {31'd0, bus_error}, 32'd0);
      chk("reset_rdata",     cpu_mem_read_data,  32'd0);
      chk("reset_cpu_en",    {31'd0, cpu_en},    32'd1);
      cyc();

      // IDLE decode table: present each access without grant, check, withdraw before the edge
      for (int i = 0; i < 6; i++) begin
         cpu_mem_write_en   = vecs[i].we;
         cpu_mem_read_en    = vecs[i].re;
         en                 = vecs[i].en;
         cpu_mem_addr       = vecs[i].addr;
         cpu_mem_write_data = vecs[i].wdata;
         #1;
         chk($sformatf("vec%0d_req", i),    {31'd0, bus_req}, {31'd0, vecs[i].x_req});
         chk($sformatf("vec%0d_we", i),     {31'd0, bus_we},  {31'd0, vecs[i].x_we});
         chk($sformatf("vec%0d_be", i),     {28'd0, bus_be},  {28'd0, vecs[i].x_be});
         chk($sformatf("vec%0d_addr", i),   bus_addr,         vecs[i].x_addr);
         chk($sformatf("vec%0d_wdata", i),  bus_wdata,        vecs[i].wdata);
         chk($sformatf("vec%0d_cpu_en", i), {31'd0, cpu_en},  {31'd0, vecs[i].x_cpu_en});
         idle_inputs();
         en = 1'b1;
         cyc();
      end

      // Read, immediate grant, rvalid one cycle later
      cpu_mem_read_en = 1'b1;
      cpu_mem_addr    = 32'h0000_0100;
      bus_gnt         = 1'b1;
      #1;
      chk("rd_req",    {31'd0, bus_req}, 32'd1);
      chk("rd_addr",   bus_addr,         32'h0000_0100);
      chk("rd_be",     {28'd0, bus_be},  32'hF);
      chk("rd_cpu_en0", {31'd0, cpu_en}, 32'd0);
      cyc();
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h1234_5678;
      #1;
      chk("rd_cpu_en1", {31'd0, cpu_en},  32'd0);
      chk("rd_req_wr",  {31'd0, bus_req}, 32'd0);
      cyc();
      bus_rvalid = 1'b0;
      bus_rdata  = 32'h0;
      #1;
      chk("rd_retire_cpu_en", {31'd0, cpu_en}, 32'd1);
      cyc();
      cpu_mem_read_en = 1'b0;
      #1;
      chk("rd_data_after", cpu_mem_read_data, 32'h1234_5678);
      chk("rd_idle_req",   {31'd0, bus_req},  32'd0);
      cyc();

      // Byte write with grant in the fourth request cycle
      cpu_mem_write_en   = 4'b0010;
      cpu_mem_addr       = 32'h0000_0203;
      cpu_mem_write_data = 32'h0000_AB00;
      req_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         bus_gnt = (i == 3);
         #1;
         if (bus_req) req_cycles++;
         if (i == 0) begin
            chk("bw_be",   {28'd0, bus_be}, 32'h2);
            chk("bw_addr", bus_addr,        32'h0000_0200);
            chk("bw_we",   {31'd0, bus_we}, 32'd1);
         end
         if (i == 2) chk("bw_stall", {31'd0, cpu_en}, 32'd0);
         cyc();
      end
      bus_gnt = 1'b0;
      #1;
      chk("bw_req_cycles", req_cycles,                32'd4);
      chk("bw_done_cpu_en", {31'd0, cpu_en},          32'd1);
      chk("bw_done_req",    {31'd0, bus_req},         32'd0);
      chk("bw_rdata_kept",  cpu_mem_read_data,        32'h1234_5678);
      cyc();
      idle_inputs();
      cyc();

      // Back-to-back read then write with grant held high throughout
      hs = 0;
      cpu_mem_read_en = 1'b1;
      cpu_mem_addr    = 32'h0000_0300;
      bus_gnt         = 1'b1;
      cyc();
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hCAFE_F00D;
      cyc();
      bus_rvalid = 1'b0;
      #1;
      chk("b2b_done_req",    {31'd0, bus_req}, 32'd0);
      chk("b2b_done_cpu_en", {31'd0, cpu_en},  32'd1);
      cyc();
      cpu_mem_read_en    = 1'b0;
      cpu_mem_write_en   = 4'hF;
      cpu_mem_addr       = 32'h0000_0304;
      cpu_mem_write_data = 32'h5A5A_5A5A;
      #1;
      chk("b2b_wr_req", {31'd0, bus_req}, 32'd1);
      cyc();
      #1;
      chk("b2b_wr_done_cpu_en", {31'd0, cpu_en},  32'd1);
      chk("b2b_wr_done_req",    {31'd0, bus_req}, 32'd0);
      cyc();
      idle_inputs();
      cyc();
      cyc();
      chk("b2b_transactions", hs,                32'd2);
      chk("b2b_rdata",        cpu_mem_read_data, 32'hCAFE_F00D);

      // Read timeout: no rvalid ever arrives
      cpu_mem_read_en = 1'b1;
      cpu_mem_addr    = 32'h0000_0400;
      bus_gnt         = 1'b1;
      cyc();
      bus_gnt = 1'b0;
      stall = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (cpu_en) break;
         stall++;
         cyc();
      end
      if (stall >= 20) $display("FAIL to_bound actual=stalled required=resume");
      chk("to_stall_cycles", stall,              32'd4);
      chk("to_bus_error",    {31'd0, bus_error}, 32'd1);
      chk("to_err_data",     cpu_mem_read_data,  32'hDEAD_BEEF);
      cyc();
      cpu_mem_read_en = 1'b0;
      #1;
      chk("to_resume_cpu_en", {31'd0, cpu_en},    32'd1);
      chk("to_error_sticky",  {31'd0, bus_error}, 32'd1);
      cyc();

      // Reset during WAIT_R, stale rvalid afterwards
      cpu_mem_read_en = 1'b1;
      cpu_mem_addr    = 32'h0000_0500;
      bus_gnt         = 1'b1;
      cyc();
      bus_gnt         = 1'b0;
      cpu_mem_read_en = 1'b0;
      rst             = 1'b1;
      cyc();
      rst        = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h5555_5555;
      cyc();
      bus_rvalid = 1'b0;
      #1;
      chk("rstw_cpu_en",    {31'd0, cpu_en},    32'd1);
      chk("rstw_bus_req",   {31'd0, bus_req},   32'd0);
      chk("rstw_bus_error", {31'd0, bus_error}, 32'd0);
      chk("rstw_rdata",     cpu_mem_read_data,  32'd0);
      cyc();

      // en low for three cycles in REQ with grant pulsing
      hs = 0;
      cpu_mem_read_en = 1'b1;
      cpu_mem_addr    = 32'h0000_0600;
      cyc();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus_gnt = (i != 1);
         #1;
         chk($sformatf("enlo%0d_cpu_en", i), {31'd0, cpu_en},  32'd0);
         chk($sformatf("enlo%0d_req", i),    {31'd0, bus_req}, 32'd1);
         cyc();
      end
      en      = 1'b1;
      bus_gnt = 1'b0;
      #1;
      chk("enhi_still_req", {31'd0, bus_req}, 32'd1);
      chk("enhi_no_hs",     hs,               32'd0);
      cyc();
      bus_gnt = 1'b1;
      cyc();
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h0000_0066;
      #1;
      chk("enhi_wait_req", {31'd0, bus_req}, 32'd0);
      chk("enhi_hs",       hs,               32'd1);
      cyc();
      bus_rvalid = 1'b0;
      #1;
      chk("enhi_retire_cpu_en", {31'd0, cpu_en},   32'd1);
      chk("enhi_rdata",         cpu_mem_read_data, 32'h0000_0066);
      cyc();
      idle_inputs();
      cyc();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
